// File: rtl/sram_block_if.sv
// Read/write port bundle for sram_block: one read address/data pair and one lane-masked write port.
// readData is the only signal driven by the memory; everything else comes from the caller.
interface sram_block_if #(
    parameter int LOGDEPTH   = 9,
    parameter int BLOCKWIDTH = 512,
    parameter int LANES      = 8
);
    logic [LOGDEPTH-1:0]   readAddr;
    logic [BLOCKWIDTH-1:0] readData;
    logic [LOGDEPTH-1:0]   writeAddr;
    logic [BLOCKWIDTH-1:0] writeData;
    logic [LANES-1:0]      writeEnable;

    modport master (
        output readAddr,
        output writeAddr,
        output writeData,
        output writeEnable,
        input  readData
    );

    modport slave (
        input  readAddr,
        input  writeAddr,
        input  writeData,
        input  writeEnable,
        output readData
    );
endinterface

// File: rtl/sram_block.sv
// 1R1W block memory with per-lane write enables; data store behind the L1 caches.
// Latency: READ_LATENCY cycles (0 = combinational); no backpressure, accepts a read and a write every cycle.
module sram_block #(
    parameter int WIDTH        = 64,
    parameter int BLOCKWIDTH   = 512,
    parameter int LOGDEPTH     = 9,
    parameter int READ_LATENCY = 0
) (
    input  logic         clk,
    input  logic         reset,
    sram_block_if.slave  bus
);
    localparam int LANES = BLOCKWIDTH / WIDTH;
    localparam int DEPTH = 1 << LOGDEPTH;

    generate
        if (BLOCKWIDTH % WIDTH != 0) begin : g_bad_width
            $fatal(1, "sram_block: BLOCKWIDTH must be an integer multiple of WIDTH");
        end
        if (READ_LATENCY < 0 || READ_LATENCY > 4) begin : g_bad_latency
            $fatal(1, "sram_block: READ_LATENCY must be in 0..4");
        end
    endgenerate

    // Contents are deliberately never reset; only the read pipeline is.
    logic [BLOCKWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.writeEnable[k]) begin
                    mem[bus.writeAddr][k*WIDTH +: WIDTH] <= bus.writeData[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign bus.readData = mem[bus.readAddr];
        end else begin : g_pipe_read
            logic [BLOCKWIDTH-1:0] pipe [READ_LATENCY];

            // Stage 0 samples the pre-write contents, giving read-before-write on collisions.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < READ_LATENCY; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= mem[bus.readAddr];
                    for (int i = 1; i < READ_LATENCY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign bus.readData = pipe[READ_LATENCY-1];
        end
    endgenerate
endmodule

// File: tb/tb_sram_block.sv
// Drives three sram_block instances (read latency 0, 1, 2) with the same stimulus and
// compares each against an array model plus a history of per-edge read samples.
module tb_sram_block;
    localparam int W     = 64;
    localparam int BW    = 512;
    localparam int LD    = 9;
    localparam int LN    = BW / W;
    localparam int DEPTH = 1 << LD;

    logic          clk = 1'b0;
    logic          rst;
    logic [LD-1:0] ra;
    logic [LD-1:0] wa;
    logic [BW-1:0] wd;
    logic [LN-1:0] we;

    int tests = 0;
    int fails = 0;

    logic [BW-1:0] model [DEPTH];
    // hist[0]: value read at the most recent edge, hist[1]: the edge before.
    logic [BW-1:0] hist [2];

    always #5 clk = ~clk;

    sram_block_if #(.LOGDEPTH(LD), .BLOCKWIDTH(BW), .LANES(LN)) bus0 ();
    sram_block_if #(.LOGDEPTH(LD), .BLOCKWIDTH(BW), .LANES(LN)) bus1 ();
    sram_block_if #(.LOGDEPTH(LD), .BLOCKWIDTH(BW), .LANES(LN)) bus2 ();

    assign bus0.readAddr = ra;  assign bus0.writeAddr = wa;
    assign bus0.writeData = wd; assign bus0.writeEnable = we;
    assign bus1.readAddr = ra;  assign bus1.writeAddr = wa;
    assign bus1.writeData = wd; assign bus1.writeEnable = we;
    assign bus2.readAddr = ra;  assign bus2.writeAddr = wa;
    assign bus2.writeData = wd; assign bus2.writeEnable = we;

    sram_block #(.WIDTH(W), .BLOCKWIDTH(BW), .LOGDEPTH(LD), .READ_LATENCY(0)) dut0 (
        .clk(clk), .reset(rst), .bus(bus0.slave));
    sram_block #(.WIDTH(W), .BLOCKWIDTH(BW), .LOGDEPTH(LD), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(rst), .bus(bus1.slave));
    sram_block #(.WIDTH(W), .BLOCKWIDTH(BW), .LOGDEPTH(LD), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(rst), .bus(bus2.slave));

    function automatic logic [BW-1:0] rnd_block();
        logic [BW-1:0] r;
        for (int j = 0; j < BW / 32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [BW-1:0] rep(input int v);
        logic [W-1:0] lane;
        lane = W'(v);
        return {LN{lane}};
    endfunction

    // Expected values that still carry X (never-written lanes) are not compared.
    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        if (!$isunknown(exp)) begin
            tests++;
            assert (obs === exp) else begin
                fails++;
                $error("FAIL %s: got %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // One clock edge: update the model as the memory would, then check all three instances.
    task automatic cycle();
        logic [BW-1:0] samp;
        @(posedge clk);
        samp = rst ? '0 : model[ra];
        if (!rst) begin
            for (int k = 0; k < LN; k++) begin
                if (we[k]) model[wa][k*W +: W] = wd[k*W +: W];
            end
        end
        hist[1] = hist[0];
        hist[0] = samp;
        #1;
        chk("lat0_read", bus0.readData, model[ra]);
        chk("lat1_read", bus1.readData, hist[0]);
        chk("lat2_read", bus2.readData, hist[1]);
    endtask

    initial begin
        logic [BW-1:0] pat;
        logic [BW-1:0] mexp;
        logic [BW-1:0] a_dat;
        logic [BW-1:0] b_dat;

        rst = 1'b1; ra = '0; wa = '0; wd = '0; we = '0;
        hist[0] = '0; hist[1] = '0;

        // Reset state of the pipelined outputs
        repeat (3) cycle();
        chk("reset_lat1_zero", bus1.readData, '0);
        chk("reset_lat2_zero", bus2.readData, '0);
        #2 rst = 1'b0;

        // Full-block write then read of entry 5
        for (int k = 0; k < LN; k++) pat[k*W +: W] = 64'h0123_4567_89AB_CDEF ^ {8{8'(k)}};
        wa = 9'd5; wd = pat; we = '1;
        cycle();
        ra = 9'd5; we = '0;
        cycle();
        chk("full_lat0", bus0.readData, pat);
        chk("full_lat1", bus1.readData, pat);
        cycle();
        chk("full_lat2", bus2.readData, pat);

        // Lane masking on entry 0x1FF
        wa = 9'h1FF; wd = '1; we = '1;
        cycle();
        wd = '0; we = 8'b0000_0101;
        cycle();
        ra = 9'h1FF; we = '0;
        cycle();
        for (int k = 0; k < LN; k++) mexp[k*W +: W] = (k == 0 || k == 2) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
        chk("mask_lat0", bus0.readData, mexp);
        chk("mask_lat1", bus1.readData, mexp);

        // Same-address collision on entry 7
        a_dat = rnd_block();
        b_dat = rnd_block();
        wa = 9'd7; wd = a_dat; we = '1;
        cycle();
        ra = 9'd7; wd = b_dat; we = '1;
        #1 chk("coll_lat0_before_edge", bus0.readData, a_dat);
        cycle();
        chk("coll_lat1_old", bus1.readData, a_dat);
        chk("coll_lat0_new", bus0.readData, b_dat);
        we = '0;
        cycle();
        chk("coll_lat1_new", bus1.readData, b_dat);

        // Write every entry while reading the previous one, across the 511->0 wrap
        for (int i = 0; i < DEPTH; i++) begin
            wa = LD'(i); wd = rep(i); we = '1; ra = LD'(i - 1);
            cycle();
            if (i > 0) begin
                chk("sweep_lat0", bus0.readData, rep(i - 1));
                chk("sweep_lat1", bus1.readData, rep(i - 1));
            end
        end
        ra = 9'h1FF; we = '0;
        cycle();
        chk("sweep_wrap_511", bus0.readData, rep(DEPTH - 1));

        // Random traffic
        repeat (300) begin
            ra = LD'($urandom); wa = LD'($urandom); wd = rnd_block(); we = LN'($urandom);
            cycle();
        end

        // Asynchronous reset mid-cycle with reads in flight
        repeat (4) begin
            ra = LD'($urandom); wa = LD'($urandom); wd = rnd_block(); we = LN'($urandom);
            cycle();
        end
        #3 rst = 1'b1;
        #1;
        chk("async_reset_lat1", bus1.readData, '0);
        chk("async_reset_lat2", bus2.readData, '0);
        chk("async_reset_lat0", bus0.readData, model[ra]);
        hist[0] = '0; hist[1] = '0;
        // Reading the address being written exposes any write that slips through reset
        repeat (6) begin
            wa = LD'($urandom); ra = wa; wd = rnd_block(); we = '1;
            cycle();
        end
        #2 rst = 1'b0;
        repeat (40) begin
            ra = LD'($urandom); we = '0; wd = rnd_block();
            cycle();
        end

        // Zero write enable with arbitrary address/data
        repeat (10) begin
            wa = LD'($urandom); wd = rnd_block(); we = '0; ra = LD'($urandom);
            cycle();
        end

        // Full readback
        for (int i = 0; i < DEPTH; i++) begin
            ra = LD'(i);
            cycle();
        end
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_block.md
Name: sram_block

Overview:
- Single-clock, one-read-port / one-write-port memory array of 2^LOGDEPTH entries, each BLOCKWIDTH bits wide.
- Entries are split into WIDTH-bit lanes; each lane has its own write enable.
- Serves as the data store behind the L1 caches. The cache addresses it as {way, index} and reads or writes whole cache blocks, with per-word write masking.

Parameters:
- WIDTH, 64: lane (word) width in bits; granularity of write enable.
- BLOCKWIDTH, 512: entry width in bits. Must be an integer multiple of WIDTH.
- LOGDEPTH, 9: log2 of entry count (512 entries).
- READ_LATENCY, 0: cycles from readAddr to readData.
  - 0 = combinational read.
  - 1..4 = registered read pipeline.
- Derived: LANES = BLOCKWIDTH/WIDTH (8).

Ports:
- clk  input  1  clock; all writes and pipeline registers update on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- readAddr  input  LOGDEPTH  read entry index.
- readData  output  BLOCKWIDTH  read entry contents.
- writeAddr  input  LOGDEPTH  write entry index.
- writeData  input  BLOCKWIDTH  write data; lane k = bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- writeEnable  input  LANES  per-lane write enable; bit k gates lane k.

Behaviour:
- Storage: array of 2^LOGDEPTH x BLOCKWIDTH bits.
  - Contents are not reset. Power-up contents are X in simulation; the bench must not depend on them.
- Write: on the rising clk edge, for each k with writeEnable[k]=1, lane k of entry writeAddr takes lane k of writeData.
  - Lanes with enable 0 keep their value.
  - writeEnable all-zero = no write.
  - Writes occur regardless of read activity.
- Read, READ_LATENCY=0: readData = array[readAddr] combinationally.
  - Reflects a write after the edge that performs it, within the same cycle (settles post-edge).
  - The L1 caches present readAddr from a register and sample readData on the next edge, so this mode satisfies them.
- Read, READ_LATENCY=N>=1: readAddr is sampled at edge t; readData shows array contents at sample time from edge t+N-1 onward.
  - Implemented as a data register pipeline of depth N.
  - A new address is accepted every cycle (fully pipelined).
- Same-address read/write collision, registered mode: read-before-write. Data sampled at the edge where the write occurs is the old content, unmasked lanes included.
- Same-address collision, combinational mode: old data before the edge, new data after the edge.
- Reset:
  - Asserting reset immediately (asynchronously) clears all read pipeline registers to 0, so readData = 0 while reset is high when READ_LATENCY>=1.
  - Writes are suppressed while reset is high.
  - Array contents are preserved across reset.
  - With READ_LATENCY=0, readData still tracks the array during reset.
- Reset mid-read: in-flight pipelined reads are discarded. The first valid data after release comes from addresses sampled after deassertion.
- Address width wraps naturally; no out-of-range addresses exist.
- No handshake; there are no stall or valid signals. The caller is responsible for timing.
- Elaboration check: BLOCKWIDTH % WIDTH must be 0, otherwise a fatal error is raised.

Test Plan:
- Full write then read:
  - Write entry 5 with all enables high; data = 512'h0123...CDEF (distinct per lane); writeEnable=8'hFF.
  - Next cycle set readAddr=5.
  - Expect readData equal to that data after READ_LATENCY cycles (immediately for latency 0).
- Lane masking:
  - Preload entry 0x1FF with all 1s.
  - Write all 0s with writeEnable=8'b0000_0101.
  - Expect lanes 0 and 2 = 0 and lanes 1,3..7 = 64'hFFFF_FFFF_FFFF_FFFF.
- Collision:
  - READ_LATENCY=1: entry 7 holds A; at the same edge write B to 7 and sample readAddr=7. Expect readData=A, then B on the next read.
  - READ_LATENCY=0: expect B after the write edge.
- Independent ports:
  - Write to entries 0..511 with data = address replicated.
  - Simultaneously read address (i-1) each cycle.
  - Expect every readData = (i-1) replicated; no corruption at 511->0 wrap.
- Reset:
  - READ_LATENCY=2, streaming reads in flight; assert reset asynchronously mid-cycle.
  - Expect readData=0 immediately and writes blocked while reset is high.
  - After release, previously written entries read back unchanged.
- Zero enable:
  - writeEnable=0 with arbitrary writeAddr/writeData for 10 cycles.
  - Expect all entries unchanged on readback.
